// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Op codes, FSM state encoding and flag indices for iter_muldiv.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_UDIV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // flags = {N, Z, DZ}
    localparam int FLAG_N  = 2;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_DZ = 0;

endpackage

`default_nettype wire

// File: rtl/cond_negate.sv
// ============================================================================
// Module   : cond_negate
// Brief    : Combinational two's-complement negate when i_en is high.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_en ? ({WIDTH{1'b0}} - i_data) : i_data;

endmodule

`default_nettype wire

// File: rtl/iter_muldiv.sv
// ============================================================================
// Module   : iter_muldiv
// Brief    : Radix-2 iterative MUL/UMULL/SMULL/UDIV unit, start/done handshake.
//            UDIV datapath compiled only when ITER_MULDIV_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       flags
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t               r_state;
    logic [1:0]           r_op;
    logic                 r_sign;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_hi;
    logic [2:0]           r_flags;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_in_smull;
    logic                 w_is_div;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [WIDTH-1:0]     w_res_lo;
    logic [WIDTH-1:0]     w_res_hi;
    logic [2:0]           w_res_flags;

    assign w_in_smull = (op == OP_SMULL);
    assign w_is_div   = (r_op == OP_UDIV);

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_en   (w_in_smull & a[WIDTH-1]),
        .i_data (a),
        .o_data (w_abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_en   (w_in_smull & b[WIDTH-1]),
        .i_data (b),
        .o_data (w_abs_b)
    );

    cond_negate #(.WIDTH(2*WIDTH)) u_fix (
        .i_en   ((r_op == OP_SMULL) & r_sign),
        .i_data (r_acc),
        .o_data (w_prod)
    );

    // Shift-add: carry-out of the upper-half add becomes the new MSB after the shift.
    assign w_addend   = r_mplr[0] ? r_mcand : {WIDTH{1'b0}};
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

`ifdef ITER_MULDIV_DIV_EN
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // Dividend bits enter from r_mplr's MSB; quotient builds in the low half.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_mplr[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_mcand};
    assign w_borrow   = (w_rem_sh < {1'b0, r_mcand});
    assign w_div_next = w_borrow ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
`else
    assign w_div_next = r_acc;
`endif

    always_comb begin
        w_res_lo    = {WIDTH{1'b0}};
        w_res_hi    = {WIDTH{1'b0}};
        w_res_flags = 3'b000;
        case (r_op)
            OP_MUL: begin
                w_res_lo            = w_prod[WIDTH-1:0];
                w_res_flags[FLAG_N] = w_prod[WIDTH-1];
                w_res_flags[FLAG_Z] = (w_prod[WIDTH-1:0] == {WIDTH{1'b0}});
            end
            OP_UMULL, OP_SMULL: begin
                w_res_lo            = w_prod[WIDTH-1:0];
                w_res_hi            = w_prod[2*WIDTH-1:WIDTH];
                w_res_flags[FLAG_N] = w_prod[2*WIDTH-1];
                w_res_flags[FLAG_Z] = (w_prod == {2*WIDTH{1'b0}});
            end
            default: begin
`ifdef ITER_MULDIV_DIV_EN
                w_res_lo             = r_acc[WIDTH-1:0];
                w_res_hi             = r_acc[2*WIDTH-1:WIDTH];
                w_res_flags[FLAG_N]  = r_acc[WIDTH-1];
                w_res_flags[FLAG_Z]  = (r_acc == {2*WIDTH{1'b0}});
                w_res_flags[FLAG_DZ] = r_dz;
`else
                w_res_flags[FLAG_Z]  = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_MUL;
            r_sign  <= 1'b0;
            r_dz    <= 1'b0;
            r_mcand <= {WIDTH{1'b0}};
            r_mplr  <= {WIDTH{1'b0}};
            r_acc   <= {2*WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= {WIDTH{1'b0}};
            r_hi    <= {WIDTH{1'b0}};
            r_flags <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_sign  <= w_in_smull & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ITER_MULDIV_DIV_EN
                        r_dz    <= (op == OP_UDIV) && (b == {WIDTH{1'b0}});
`else
                        r_dz    <= 1'b0;
`endif
                        r_mcand <= (op == OP_UDIV) ? b : w_abs_a;
                        r_mplr  <= (op == OP_UDIV) ? a : w_abs_b;
                        r_acc   <= {2*WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_is_div ? w_div_next : w_mul_next;
                    r_mplr <= w_is_div ? {r_mplr[WIDTH-2:0], 1'b0}
                                       : {1'b0, r_mplr[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_res_lo;
                    r_hi    <= w_res_hi;
                    r_flags <= w_res_flags;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv.sv
// ============================================================================
// Module   : tb_iter_muldiv
// Brief    : Self-checking bench for iter_muldiv (WIDTH=32) with an arithmetic
//            reference model; honours ITER_MULDIV_DIV_EN like the DUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iter_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic [2:0]    flags;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    iter_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of one operation, straight from the arithmetic definition.
    task automatic model_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic [2:0] f);
        logic [2*W-1:0]        p;
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        lo = '0; hi = '0; f = 3'b000; p = '0;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        case (o)
            2'b00: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                lo = p[W-1:0];
                f[2] = lo[W-1];
                f[1] = (lo == 0);
            end
            2'b01, 2'b10: begin
                if (o == 2'b01) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                else            p = sx * sy;
                lo = p[W-1:0];
                hi = p[2*W-1:W];
                f[2] = hi[W-1];
                f[1] = (p == 0);
            end
            default: begin
`ifdef ITER_MULDIV_DIV_EN
                if (y == 0) begin
                    lo = '1; hi = x; f[0] = 1'b1;
                end else begin
                    lo = x / y; hi = x % y;
                end
                f[2] = lo[W-1];
                f[1] = (lo == 0) && (hi == 0);
`else
                f = 3'b010;
`endif
            end
        endcase
    endtask

    // Reference timeline: an accepted request delivers done W+1 edges later.
    int           m_left = 0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic [2:0]   m_flags = 3'b000, p_flags = 3'b000;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0;
            m_lo = '0; m_hi = '0; m_flags = 3'b000;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_lo = p_lo; m_hi = p_hi; m_flags = p_flags;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                model_result(op, a, b, p_lo, p_hi, p_flags);
                m_left = W + 1;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      {31'd0, busy}, {31'd0, m_busy});
            check("done",      {31'd0, done}, {31'd0, m_done});
            check("result_lo", result_lo, m_lo);
            check("result_hi", result_hi, m_hi);
            check("flags",     {29'd0, flags}, {29'd0, m_flags});
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle (or timeout).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inj, output int cnt);
        start = 1'b1; op = o; a = x; b = y;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
            end
            if (cnt == inj) begin
                start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
            end
            if (cnt == inj + 1) start = 1'b0;
        end while (!done && cnt < 100);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int           cnt;
        bit           seen_done;
        logic [W-1:0] e_lo, e_hi;
        logic [2:0]   e_f;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lo",   result_lo, 32'd0);
        check("rst_flags", {29'd0, flags}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, -1, cnt);
        check("mul_lat", cnt, 32'd34);
        check("mul_lo", result_lo, 32'h0000_002A);
        check("mul_hi", result_hi, 32'd0);
        check("mul_flags", {29'd0, flags}, 32'd0);
        @(negedge clk);

        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, -1, cnt);
        check("smull_hi", result_hi, 32'hFFFF_FFFF);
        check("smull_lo", result_lo, 32'hFFFF_FFF1);
        check("smull_flags", {29'd0, flags}, 32'd4);
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, cnt);
        check("umull_hi", result_hi, 32'hFFFF_FFFE);
        check("umull_lo", result_lo, 32'h0000_0001);
        run_op(2'b00, 32'd0, 32'd9, -1, cnt);
        check("b2b_lat", cnt, 32'd34);
        check("b2b_flags", {29'd0, flags}, 32'd2);
        @(negedge clk);

        run_op(2'b11, 32'd100, 32'd7, -1, cnt);
`ifdef ITER_MULDIV_DIV_EN
        check("div_q", result_lo, 32'd14);
        check("div_r", result_hi, 32'd2);
`else
        check("div_lo", result_lo, 32'd0);
        check("div_flags", {29'd0, flags}, 32'd2);
`endif
        run_op(2'b11, 32'd5, 32'd0, -1, cnt);
        check("dz_lat", cnt, 32'd34);
`ifdef ITER_MULDIV_DIV_EN
        check("dz_q", result_lo, 32'hFFFF_FFFF);
        check("dz_r", result_hi, 32'd5);
        check("dz_flag", {31'd0, flags[0]}, 32'd1);
`else
        check("dz_hi", result_hi, 32'd0);
        check("dz_flags", {29'd0, flags}, 32'd2);
`endif
        @(negedge clk);

        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10, cnt);
        model_result(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, e_lo, e_hi, e_f);
        check("ign_lat", cnt, 32'd34);
        check("ign_lo", result_lo, e_lo);
        check("ign_hi", result_hi, e_hi);
        @(negedge clk);

        // Abort a run with reset mid-flight.
        start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", result_hi, 32'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        run_op(2'b00, 32'd3, 32'd4, -1, cnt);
        check("post_rst_lo", result_lo, 32'd12);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ro, ra, rb, (i % 5 == 0) ? 20 : -1, cnt);
            check("rnd_lat", cnt, 32'd34);
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
